// File: rtl/sipo_deser_if.sv
// sipo_deser_if: serial-in side and parallel valid/ready side of the
// deserialiser, grouped for connection as a single port.
//   slave  : the deserialiser (takes sin/sin_valid/sin_start/q_ready/ovr_clr,
//            drives q/q_valid/overrun/bit_cnt)
//   master : the environment (serial source plus word consumer)
interface sipo_deser_if #(
  parameter int WIDTH = 4
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             sin;
  logic             sin_valid;
  logic             sin_start;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic             q_ready;
  logic             overrun;
  logic             ovr_clr;
  logic [CW-1:0]    bit_cnt;

  modport slave (
    input  sin, sin_valid, sin_start, q_ready, ovr_clr,
    output q, q_valid, overrun, bit_cnt
  );

  modport master (
    output sin, sin_valid, sin_start, q_ready, ovr_clr,
    input  q, q_valid, overrun, bit_cnt
  );
endinterface

// File: rtl/sipo_deser.sv
// sipo_deser: serial-in, parallel-out receiver for the LSB-first,
// one-bit-per-strobe serial link. Collects WIDTH qualified bits into a word,
// holds it on a valid/ready interface and flags a sticky overrun when a
// completed word has to be dropped because the consumer is stalling.
// Ports:
//   clk    : clock, all state changes on the rising edge
//   reset  : synchronous, active-high
//   bus    : sipo_deser_if.slave (sin, sin_valid, sin_start, q, q_valid,
//            q_ready, overrun, ovr_clr, bit_cnt)
module sipo_deser #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  sipo_deser_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             q_valid_q, q_valid_d;
  logic             overrun_q, overrun_d;
  logic             word_done;
  logic             ovr_set;

  always_comb begin
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    q_d       = q_q;
    q_valid_d = q_valid_q;
    word_done = 1'b0;
    ovr_set   = 1'b0;

    if (bus.sin_valid) begin
      if (MSB_FIRST)
        shreg_d = {shreg_q[WIDTH-2:0], bus.sin};
      else
        shreg_d = {bus.sin, shreg_q[WIDTH-1:1]};

      // A start-flagged bit is always bit 0 of a new word; stale register
      // contents are shifted out before the word can complete.
      if (bus.sin_start) begin
        bit_cnt_d = CW'(1);
      end else if (bit_cnt_q == CW'(WIDTH - 1)) begin
        bit_cnt_d = '0;
        word_done = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + CW'(1);
      end
    end else if (bus.sin_start) begin
      bit_cnt_d = '0;
    end

    if (word_done) begin
      // Free slot, or the held word is leaving on this same edge.
      if (!q_valid_q || bus.q_ready) begin
        q_d       = shreg_d;
        q_valid_d = 1'b1;
      end else begin
        ovr_set   = 1'b1;
      end
    end else if (q_valid_q && bus.q_ready) begin
      q_valid_d = 1'b0;
    end

    // Set has priority over clear.
    overrun_d = ovr_set | (overrun_q & ~bus.ovr_clr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.q       = q_q;
  assign bus.q_valid = q_valid_q;
  assign bus.overrun = overrun_q;
  assign bus.bit_cnt = bit_cnt_q;
endmodule

// File: tb/tb_sipo_deser.sv
// tb_sipo_deser: directed bench for sipo_deser. Two instances (LSB-first and
// MSB-first) share one stimulus stream; a word-level model predicts both.
module tb_sipo_deser;
  localparam int W = 4;

  logic clk = 1'b0;
  logic reset;
  logic sin, sin_valid, sin_start, q_ready, ovr_clr;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  sipo_deser_if #(.WIDTH(W)) if0 ();
  sipo_deser_if #(.WIDTH(W)) if1 ();

  assign if0.sin = sin;  assign if0.sin_valid = sin_valid;
  assign if0.sin_start = sin_start;  assign if0.q_ready = q_ready;
  assign if0.ovr_clr = ovr_clr;
  assign if1.sin = sin;  assign if1.sin_valid = sin_valid;
  assign if1.sin_start = sin_start;  assign if1.q_ready = q_ready;
  assign if1.ovr_clr = ovr_clr;

  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));

  always #5 clk = ~clk;

  // Model: list of bits received in the current word; words are built from
  // bit positions, not by shifting.
  bit       mb[W];
  int       m_cnt;
  bit [W-1:0] m_q0, m_q1;
  bit       m_valid, m_ovr;

  always @(posedge clk) begin
    bit done, set;
    bit [W-1:0] w0, w1;
    done = 1'b0; set = 1'b0;
    if (reset) begin
      m_cnt = 0; m_q0 = '0; m_q1 = '0; m_valid = 1'b0; m_ovr = 1'b0;
    end else begin
      if (sin_valid) begin
        if (sin_start) m_cnt = 0;
        mb[m_cnt] = sin;
        m_cnt++;
        if (m_cnt == W) begin
          done = 1'b1;
          m_cnt = 0;
        end
      end else if (sin_start) begin
        m_cnt = 0;
      end
      for (int i = 0; i < W; i++) begin
        w0[i]       = mb[i];
        w1[W-1-i]   = mb[i];
      end
      if (done) begin
        if (!m_valid || q_ready) begin
          m_q0 = w0; m_q1 = w1; m_valid = 1'b1;
        end else begin
          set = 1'b1;
        end
      end else if (m_valid && q_ready) begin
        m_valid = 1'b0;
      end
      m_ovr = set | (m_ovr & ~ovr_clr);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_q0",      32'(if0.q),       32'(m_q0));
      chk("cyc_q1",      32'(if1.q),       32'(m_q1));
      chk("cyc_valid0",  32'(if0.q_valid), 32'(m_valid));
      chk("cyc_valid1",  32'(if1.q_valid), 32'(m_valid));
      chk("cyc_ovr0",    32'(if0.overrun), 32'(m_ovr));
      chk("cyc_ovr1",    32'(if1.overrun), 32'(m_ovr));
      chk("cyc_cnt0",    32'(if0.bit_cnt), 32'(m_cnt));
      chk("cyc_cnt1",    32'(if1.bit_cnt), 32'(m_cnt));
    end
  end

  task automatic bitx(input logic b, input logic st);
    sin = b; sin_valid = 1'b1; sin_start = st;
    @(posedge clk); #1;
    sin_valid = 1'b0; sin_start = 1'b0; sin = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_word(input logic [3:0] w, input bit gap);
    for (int i = 0; i < W; i++) begin
      bitx(w[i], 1'b0);
      if (gap && i != W-1) idle(1);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; idle(2); reset = 1'b0;
  endtask

  initial begin
    logic [3:0] b;
    sin = 0; sin_valid = 0; sin_start = 0; q_ready = 1; ovr_clr = 0; reset = 1;
    idle(2);
    reset = 1'b0;
    chk_en = 1'b1;

    // reset state
    chk("rst_q",     32'(if0.q),       0);
    chk("rst_valid", 32'(if0.q_valid), 0);
    chk("rst_ovr",   32'(if0.overrun), 0);
    chk("rst_cnt",   32'(if0.bit_cnt), 0);

    // single word 1,1,0,1 -> 0xB, bit_cnt 1,2,3,0
    b = 4'b1011;
    for (int i = 0; i < W; i++) begin
      bitx(b[i], 1'b0);
      chk("single_cnt", 32'(if0.bit_cnt), (i + 1) % 4);
    end
    chk("single_q",     32'(if0.q), 32'hB);
    chk("single_model", 32'(m_q0), 32'hB);
    chk("single_msb",   32'(if1.q), 32'hD);
    chk("single_valid", 32'(if0.q_valid), 1);
    idle(1);
    chk("single_1cyc",  32'(if0.q_valid), 0);

    // gapped 0xB then back-to-back 0x6
    send_word(4'hB, 1'b1);
    chk("gap_q", 32'(if0.q), 32'hB);
    send_word(4'h6, 1'b0);
    chk("b2b_q",   32'(if0.q), 32'h6);
    chk("b2b_ovr", 32'(if0.overrun), 0);
    idle(1);

    // stall and overrun
    q_ready = 1'b0;
    send_word(4'h3, 1'b0);
    chk("stall_q1", 32'(if0.q), 32'h3);
    send_word(4'hC, 1'b0);
    chk("stall_q2",     32'(if0.q), 32'h3);
    chk("stall_valid",  32'(if0.q_valid), 1);
    chk("stall_ovr",    32'(if0.overrun), 1);
    chk("stall_cnt",    32'(if0.bit_cnt), 0);
    q_ready = 1'b1; idle(1); q_ready = 1'b0;
    chk("accept_valid", 32'(if0.q_valid), 0);
    chk("accept_ovr",   32'(if0.overrun), 1);
    ovr_clr = 1'b1; idle(1); ovr_clr = 1'b0;
    chk("clr_ovr",      32'(if0.overrun), 0);

    // clear and new overrun on the same edge: set wins
    send_word(4'h3, 1'b0);
    b = 4'hC;
    for (int i = 0; i < W-1; i++) bitx(b[i], 1'b0);
    ovr_clr = 1'b1;
    bitx(b[W-1], 1'b0);
    ovr_clr = 1'b0;
    chk("setwins_ovr", 32'(if0.overrun), 1);
    chk("setwins_q",   32'(if0.q), 32'h3);
    q_ready = 1'b1; ovr_clr = 1'b1; idle(1); ovr_clr = 1'b0; q_ready = 1'b0;

    // simultaneous accept and complete
    send_word(4'h5, 1'b0);
    chk("sim_hold", 32'(if0.q), 32'h5);
    b = 4'hA;
    for (int i = 0; i < W-1; i++) bitx(b[i], 1'b0);
    q_ready = 1'b1;
    bitx(b[W-1], 1'b0);
    chk("sim_q",     32'(if0.q), 32'hA);
    chk("sim_valid", 32'(if0.q_valid), 1);
    chk("sim_ovr",   32'(if0.overrun), 0);
    idle(1);

    // resync with sin_start+sin_valid
    bitx(1'b1, 1'b0); bitx(1'b1, 1'b0);
    bitx(1'b1, 1'b1);
    chk("resync_cnt", 32'(if0.bit_cnt), 1);
    bitx(1'b0, 1'b0);
    chk("resync_nowd", 32'(if0.q_valid), 0);
    bitx(1'b0, 1'b0); bitx(1'b1, 1'b0);
    chk("resync_q", 32'(if0.q), 32'h9);
    idle(1);

    // sin_start without sin_valid clears the partial word
    bitx(1'b1, 1'b0); bitx(1'b0, 1'b0);
    sin_start = 1'b1; idle(1); sin_start = 1'b0;
    chk("start_novalid_cnt", 32'(if0.bit_cnt), 0);
    chk("start_novalid_v",   32'(if0.q_valid), 0);

    // MSB_FIRST=1: 1,0,0,0 -> 0x8; then reset mid-word with a held word
    do_reset();
    q_ready = 1'b0;
    bitx(1'b1, 1'b0); bitx(1'b0, 1'b0); bitx(1'b0, 1'b0); bitx(1'b0, 1'b0);
    chk("msb_q",  32'(if1.q), 32'h8);
    chk("lsb_q",  32'(if0.q), 32'h1);
    bitx(1'b1, 1'b0); bitx(1'b1, 1'b0);
    reset = 1'b1; idle(1); reset = 1'b0;
    chk("midrst_cnt",   32'(if1.bit_cnt), 0);
    chk("midrst_valid", 32'(if1.q_valid), 0);
    chk("midrst_q",     32'(if1.q), 0);
    q_ready = 1'b1;
    send_word(4'h9, 1'b0);
    chk("post_rst_q", 32'(if0.q), 32'h9);
    idle(2);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sipo_deser.md
Name: sipo_deser

Overview:
- Serial-in, parallel-out receiver for the team's LSB-first, one-bit-per-strobe serial link; the receiving end of the 4-bit parallel-in/serial-out shifter.
- Collects WIDTH qualified serial bits into a word and presents it on a valid/ready parallel interface.
- Flags overrun when the consumer stalls.
- Sits between the serial link and downstream word-wide logic.

Parameters:
- WIDTH, 4, bits per word; legal range is 2 or more.
- MSB_FIRST, 0: 0 means the first received bit lands in q[0]; 1 means the first received bit lands in q[WIDTH-1].

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- sin  input  1  serial data bit.
- sin_valid  input  1  sin is sampled only on cycles where sin_valid=1.
- sin_start  input  1  marks the first bit of a word and resynchronises the bit counter.
- q  output  WIDTH  received word; stable while q_valid=1.
- q_valid  output  1  q holds an unconsumed word.
- q_ready  input  1  consumer accepts q when q_valid=1 and q_ready=1.
- overrun  output  1  sticky; a completed word was dropped.
- ovr_clr  input  1  clears overrun.
- bit_cnt  output  clog2(WIDTH+1)  number of bits collected in the current partial word.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values: shreg=0, bit_cnt=0, q=0, q_valid=0, overrun=0. reset overrides every other input in the same cycle. Reset mid-word discards the partial word and any held word.
- Shift rule, on a sin_valid=1 cycle:
  - MSB_FIRST=0: shreg <= {sin, shreg[WIDTH-1:1]}.
  - MSB_FIRST=1: shreg <= {shreg[WIDTH-2:0], sin}.
- Bit counter:
  - On sin_valid=1: bit_cnt increments.
  - On the bit that reaches WIDTH: bit_cnt returns to 0 and the word completes.
- Word completion: on the same edge that samples the last bit, the assembled word (including that bit) is written to q and q_valid is set. Latency is 0 cycles after the last sampling edge, so q/q_valid are visible in the following cycle.
- Consumer handshake:
  - Transfer occurs when q_valid=1 and q_ready=1. q_valid clears on the next edge unless a new word completes on that same edge.
  - q_ready is ignored while q_valid=0.
  - q and q_valid have no combinational path from q_ready.
- Simultaneous completion and acceptance: the new word loads into q and q_valid stays 1. No overrun.
- Completion while q_valid=1 and q_ready=0:
  - The new word is dropped, and q keeps the old word.
  - overrun is set to 1. bit_cnt still returns to 0.
- overrun stays set until ovr_clr=1 or reset. If ovr_clr=1 and a new overrun event occur on the same edge, overrun remains 1 (set wins).
- sin_start:
  - With sin_valid=1: the partial word is discarded and the bit is taken as bit 0 of a new word, so bit_cnt becomes 1.
  - With sin_valid=0: the partial word is discarded and bit_cnt becomes 0.
  - sin_start never affects q, q_valid or overrun.
- sin is ignored on sin_valid=0 cycles. Idle cycles between bits are allowed and do not change state.
- Back-to-back words with no idle cycles are supported at full rate of one bit per clk.

Test Plan:
- Reset then single word: WIDTH=4, MSB_FIRST=0, bits 1,1,0,1 on four consecutive sin_valid cycles with q_ready=1. Required: q=4'hB and q_valid=1 for exactly one cycle after the 4th edge; bit_cnt sequence 1,2,3,0.
- Gapped bits and back-to-back words: send 0xB with sin_valid=0 gaps between bits, then 0x6 (bits 0,1,1,0) immediately after. Required: q=4'hB, then q=4'h6; overrun=0.
- Stall and overrun: q_ready=0, send 0x3 then 0xC. Required: q stays 4'h3 with q_valid=1; overrun=1 after the 2nd word's last edge. Then q_ready=1 for one cycle makes q_valid=0. Then ovr_clr=1 makes overrun=0.
- Simultaneous accept and complete: hold 0x5 with q_ready=0, then assert q_ready=1 on the edge the last bit of 0xA arrives. Required: q=4'hA, q_valid stays 1, overrun=0.
- Resync: send 2 bits of 0xF, then assert sin_start with sin_valid=1 and send 0x9. Required: q=4'h9; no word is produced from the partial 0xF bits.
- Reset mid-word and MSB_FIRST=1: with MSB_FIRST=1, bits 1,0,0,0 give q=4'h8. Asserting reset after 2 bits of a word gives bit_cnt=0, q_valid=0, q=0.
